// File: rtl/dds_sweep_if.sv
// ICB register bus between a host (master) and the DDS block (slave).
interface dds_sweep_if;
  logic        icb_wr;
  logic [7:0]  icb_wadr;
  logic [31:0] icb_wdat;
  logic        icb_wack;
  logic        icb_rd;
  logic [7:0]  icb_radr;
  logic [31:0] icb_rdat;
  logic        icb_rack;

  modport master (
    output icb_wr, icb_wadr, icb_wdat, icb_rd, icb_radr,
    input  icb_wack, icb_rdat, icb_rack
  );

  modport slave (
    input  icb_wr, icb_wadr, icb_wdat, icb_rd, icb_radr,
    output icb_wack, icb_rdat, icb_rack
  );
endinterface

// File: rtl/dds_sweep.sv
// DDS generator with a phase accumulator, a phase offset, an external sin/cos table
// and a frequency-sweep FSM (one-shot or triangular chirp), configured over ICB.
// The start and acc_clr command bits are captured into one-cycle pulse registers.
// This lets a single CTRL write set en/sweep_en and start a sweep at the same time.
// The start command is a control action and is honoured even while en=0.
// Stepping, the dwell counter and the datapath only advance while en=1.
module dds_sweep #(
  parameter int PW  = 32,
  parameter int AW  = 10,
  parameter int DW  = 16,
  parameter int DCW = 16
) (
  input  logic          clk,
  input  logic          rst_,
  dds_sweep_if.slave    icb,
  output logic [AW-1:0] lut_addr,
  input  logic [DW-1:0] lut_sin,
  input  logic [DW-1:0] lut_cos,
  output logic [DW-1:0] sin_dout,
  output logic [DW-1:0] cos_dout,
  output logic          dout_vld,
  output logic          sweep_irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [7:0] A_START  = 8'd0;
  localparam logic [7:0] A_STOP   = 8'd1;
  localparam logic [7:0] A_STEP   = 8'd2;
  localparam logic [7:0] A_DWELL  = 8'd3;
  localparam logic [7:0] A_OFS    = 8'd4;
  localparam logic [7:0] A_CTRL   = 8'd5;
  localparam logic [7:0] A_STATUS = 8'd6;
  localparam logic [7:0] A_CUR    = 8'd7;

  // configuration registers
  logic [PW-1:0]  fcw_start_reg;
  logic [PW-1:0]  fcw_stop_reg;
  logic [PW-1:0]  fcw_step_reg;
  logic [PW-1:0]  phase_ofs_reg;
  logic [DCW-1:0] dwell_reg;
  logic           en_reg;
  logic           sweep_en_reg;
  logic           mode_reg;
  logic           start_pls_reg;
  logic           acc_clr_pls_reg;

  // sweep state
  state_t         state_reg, state_next;
  logic [PW-1:0]  cur_fcw_reg, cur_fcw_next;
  logic [DCW-1:0] cnt_reg, cnt_next;
  logic           done_reg, done_next;
  logic           irq_next;

  // datapath
  logic [PW-1:0]  acc_reg;
  logic [PW-1:0]  phase;
  logic [PW:0]    step_sum;
  logic [PW:0]    step_diff;
  logic           ctrl_wr;

  assign ctrl_wr       = icb.icb_wr && (icb.icb_wadr == A_CTRL);
  assign icb.icb_wack  = icb.icb_wr;
  assign icb.icb_rack  = icb.icb_rd;

  // Register file writes; command bits become single-cycle pulses.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      fcw_start_reg   <= '0;
      fcw_stop_reg    <= '0;
      fcw_step_reg    <= '0;
      phase_ofs_reg   <= '0;
      dwell_reg       <= '0;
      en_reg          <= 1'b0;
      sweep_en_reg    <= 1'b0;
      mode_reg        <= 1'b0;
      start_pls_reg   <= 1'b0;
      acc_clr_pls_reg <= 1'b0;
    end else begin
      start_pls_reg   <= ctrl_wr && icb.icb_wdat[3];
      acc_clr_pls_reg <= ctrl_wr && icb.icb_wdat[4];
      if (icb.icb_wr) begin
        case (icb.icb_wadr)
          A_START: fcw_start_reg <= icb.icb_wdat[PW-1:0];
          A_STOP:  fcw_stop_reg  <= icb.icb_wdat[PW-1:0];
          A_STEP:  fcw_step_reg  <= icb.icb_wdat[PW-1:0];
          A_DWELL: dwell_reg     <= icb.icb_wdat[DCW-1:0];
          A_OFS:   phase_ofs_reg <= icb.icb_wdat[PW-1:0];
          A_CTRL: begin
            en_reg       <= icb.icb_wdat[0];
            sweep_en_reg <= icb.icb_wdat[1];
            mode_reg     <= icb.icb_wdat[2];
          end
          default: ;
        endcase
      end
    end
  end

  // Combinational register read-back; unmapped addresses read as zero.
  always_comb begin
    icb.icb_rdat = '0;
    case (icb.icb_radr)
      A_START:  icb.icb_rdat = 32'(fcw_start_reg);
      A_STOP:   icb.icb_rdat = 32'(fcw_stop_reg);
      A_STEP:   icb.icb_rdat = 32'(fcw_step_reg);
      A_DWELL:  icb.icb_rdat = 32'(dwell_reg);
      A_OFS:    icb.icb_rdat = 32'(phase_ofs_reg);
      A_CTRL:   icb.icb_rdat = {29'd0, mode_reg, sweep_en_reg, en_reg};
      A_STATUS: icb.icb_rdat = {29'd0, done_reg, state_reg};
      A_CUR:    icb.icb_rdat = 32'(cur_fcw_reg);
      default:  icb.icb_rdat = '0;
    endcase
  end

  // One extra bit catches carry on the way up and borrow on the way down.
  assign step_sum  = {1'b0, cur_fcw_reg} + {1'b0, fcw_step_reg};
  assign step_diff = {1'b0, cur_fcw_reg} - {1'b0, fcw_step_reg};

  // Sweep FSM state register.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_reg   <= IDLE;
      cur_fcw_reg <= '0;
      cnt_reg     <= '0;
      done_reg    <= 1'b0;
      sweep_irq   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cur_fcw_reg <= cur_fcw_next;
      cnt_reg     <= cnt_next;
      done_reg    <= done_next;
      sweep_irq   <= irq_next;
    end
  end

  // Sweep FSM next state: disable wins, then start, then dwell-paced stepping.
  always_comb begin
    state_next   = state_reg;
    cur_fcw_next = cur_fcw_reg;
    cnt_next     = cnt_reg;
    done_next    = done_reg;
    irq_next     = 1'b0;
    if (!sweep_en_reg) begin
      state_next   = IDLE;
      cur_fcw_next = fcw_start_reg;
      cnt_next     = '0;
      done_next    = 1'b0;
    end else if (start_pls_reg) begin
      cur_fcw_next = fcw_start_reg;
      cnt_next     = '0;
      done_next    = 1'b0;
      if (fcw_start_reg >= fcw_stop_reg) begin
        state_next = DONE;
        done_next  = 1'b1;
        irq_next   = 1'b1;
      end else begin
        state_next = UP;
      end
    end else begin
      case (state_reg)
        IDLE: cur_fcw_next = fcw_start_reg;
        UP, DOWN: begin
          if (en_reg) begin
            if (cnt_reg == dwell_reg) begin
              cnt_next = '0;
              if (state_reg == UP) begin
                if (step_sum >= {1'b0, fcw_stop_reg}) begin
                  cur_fcw_next = fcw_stop_reg;
                  if (mode_reg) begin
                    state_next = DOWN;
                  end else begin
                    state_next = DONE;
                    done_next  = 1'b1;
                    irq_next   = 1'b1;
                  end
                end else begin
                  cur_fcw_next = step_sum[PW-1:0];
                end
              end else begin
                if (step_diff[PW] || (step_diff[PW-1:0] <= fcw_start_reg)) begin
                  cur_fcw_next = fcw_start_reg;
                  state_next   = UP;
                end else begin
                  cur_fcw_next = step_diff[PW-1:0];
                end
              end
            end else begin
              cnt_next = cnt_reg + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Phase accumulator; a clear pulse overrides the accumulate.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      acc_reg <= '0;
    end else if (acc_clr_pls_reg) begin
      acc_reg <= '0;
    end else if (en_reg) begin
      acc_reg <= acc_reg + cur_fcw_reg;
    end
  end

  assign phase    = acc_reg + phase_ofs_reg;
  assign lut_addr = phase[PW-1:PW-AW];

  // Capture table outputs one cycle behind the accumulator.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      sin_dout <= '0;
      cos_dout <= '0;
      dout_vld <= 1'b0;
    end else begin
      dout_vld <= en_reg;
      if (en_reg) begin
        sin_dout <= lut_sin;
        cos_dout <= lut_cos;
      end
    end
  end

endmodule

// File: tb/tb_dds_sweep.sv
// Self-checking bench for dds_sweep: register access, accumulator/offset datapath,
// and sweep trajectories checked against a plateau-based reference model.
module tb_dds_sweep;
  logic        clk;
  logic        rst_;
  logic [9:0]  lut_addr;
  logic [15:0] lut_sin;
  logic [15:0] lut_cos;
  logic [15:0] sin_dout;
  logic [15:0] cos_dout;
  logic        dout_vld;
  logic        sweep_irq;
  int          vectors;
  int          miscompares;

  dds_sweep_if bus ();

  dds_sweep #(.PW(32), .AW(10), .DW(16), .DCW(16)) dut (
    .clk       (clk),
    .rst_      (rst_),
    .icb       (bus),
    .lut_addr  (lut_addr),
    .lut_sin   (lut_sin),
    .lut_cos   (lut_cos),
    .sin_dout  (sin_dout),
    .cos_dout  (cos_dout),
    .dout_vld  (dout_vld),
    .sweep_irq (sweep_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] f_sin(input logic [9:0] a);
    return {a, 6'h15} ^ 16'hA5C3;
  endfunction

  function automatic logic [15:0] f_cos(input logic [9:0] a);
    return ~{6'h2a, a};
  endfunction

  assign lut_sin = f_sin(lut_addr);
  assign lut_cos = f_cos(lut_addr);

  task automatic wr_reg(input logic [7:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.icb_wr   = 1'b1;
    bus.icb_wadr = a;
    bus.icb_wdat = d;
    @(posedge clk); #1;
    bus.icb_wr   = 1'b0;
  endtask

  task automatic rd_reg(input logic [7:0] a, output logic [31:0] d);
    bus.icb_rd   = 1'b1;
    bus.icb_radr = a;
    #1;
    d = bus.icb_rdat;
    bus.icb_rd   = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_ = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    vectors++; if (sin_dout !== 16'h0) begin miscompares++; $display("FAIL reset_sin: got %h expected 0", sin_dout); end
    vectors++; if (cos_dout !== 16'h0) begin miscompares++; $display("FAIL reset_cos: got %h expected 0", cos_dout); end
    vectors++; if (dout_vld !== 1'b0) begin miscompares++; $display("FAIL reset_vld: got %b expected 0", dout_vld); end
    vectors++; if (sweep_irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq: got %b expected 0", sweep_irq); end
    vectors++; if (lut_addr !== 10'h0) begin miscompares++; $display("FAIL reset_addr: got %h expected 0", lut_addr); end
    for (int a = 0; a < 8; a++) begin
      rd_reg(8'(a), d);
      vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL reset_reg%0d: got %h expected 0", a, d); end
    end
    rst_ = 1'b1;
  endtask

  task automatic test_regs();
    logic [31:0] v [5];
    logic [31:0] d;
    logic [31:0] e;
    for (int i = 0; i < 5; i++) begin
      v[i] = $urandom;
      wr_reg(8'(i), v[i]);
    end
    vectors++; if (bus.icb_wack !== 1'b0) begin miscompares++; $display("FAIL wack_idle: got %b expected 0", bus.icb_wack); end
    for (int i = 0; i < 5; i++) begin
      rd_reg(8'(i), d);
      e = (i == 3) ? (v[i] & 32'h0000_ffff) : v[i];
      vectors++; if (d !== e) begin miscompares++; $display("FAIL reg_rw%0d: got %h expected %h", i, d, e); end
    end
    wr_reg(8'd5, 32'h0000_001e);
    rd_reg(8'd5, d);
    vectors++; if (d !== 32'h6) begin miscompares++; $display("FAIL ctrl_rd: got %h expected 6", d); end
    wr_reg(8'd5, 32'h0);
    wr_reg(8'h20, 32'hdead_beef);
    rd_reg(8'd0, d);
    vectors++; if (d !== v[0]) begin miscompares++; $display("FAIL unmapped_wr: got %h expected %h", d, v[0]); end
    rd_reg(8'h20, d);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL unmapped_rd: got %h expected 0", d); end
    bus.icb_rd = 1'b1; bus.icb_radr = 8'h20; #1;
    vectors++; if (bus.icb_rack !== 1'b1) begin miscompares++; $display("FAIL rack: got %b expected 1", bus.icb_rack); end
    bus.icb_rd = 1'b0; #1;
    vectors++; if (bus.icb_rack !== 1'b0) begin miscompares++; $display("FAIL rack_low: got %b expected 0", bus.icb_rack); end
  endtask

  // Clears acc with en=0, then runs n cycles with en=1 against a running phase sum.
  task automatic run_acc(input logic [31:0] fcw, input logic [31:0] ofs, input int n);
    logic [31:0] acc_m;
    logic [31:0] ph;
    logic [9:0]  ea;
    logic [9:0]  prev_addr;
    wr_reg(8'd5, 32'h0);
    wr_reg(8'd0, fcw);
    wr_reg(8'd4, ofs);
    wr_reg(8'd5, 32'h10);
    repeat (2) @(posedge clk);
    wr_reg(8'd5, 32'h1);
    acc_m = 32'h0;
    prev_addr = 10'h0;
    for (int k = 0; k < n; k++) begin
      ph = acc_m + ofs;
      ea = ph[31:22];
      vectors++; if (lut_addr !== ea) begin miscompares++; $display("FAIL acc_addr k=%0d: got %h expected %h", k, lut_addr, ea); end
      vectors++; if (dout_vld !== (k > 0)) begin miscompares++; $display("FAIL dout_vld k=%0d: got %b expected %b", k, dout_vld, (k > 0)); end
      if (k > 0) begin
        vectors++; if (sin_dout !== f_sin(prev_addr)) begin miscompares++; $display("FAIL sin_dout k=%0d: got %h expected %h", k, sin_dout, f_sin(prev_addr)); end
        vectors++; if (cos_dout !== f_cos(prev_addr)) begin miscompares++; $display("FAIL cos_dout k=%0d: got %h expected %h", k, cos_dout, f_cos(prev_addr)); end
      end
      prev_addr = ea;
      acc_m = acc_m + fcw;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_acc();
    run_acc(32'h0040_0000, 32'h0, 20);
    run_acc($urandom, $urandom, 12);
  endtask

  task automatic test_phase_ofs();
    run_acc(32'h0040_0000, 32'h8000_0000, 12);
  endtask

  task automatic test_acc_clr();
    logic [31:0] fcw;
    logic [31:0] ofs;
    logic [31:0] ph;
    fcw = $urandom | 32'h0100_0000;
    ofs = $urandom;
    run_acc(fcw, ofs, 5);
    wr_reg(8'd5, 32'h11);
    @(posedge clk); #1;
    vectors++; if (lut_addr !== ofs[31:22]) begin miscompares++; $display("FAIL acc_clr: got %h expected %h", lut_addr, ofs[31:22]); end
    @(posedge clk); #1;
    ph = fcw + ofs;
    vectors++; if (lut_addr !== ph[31:22]) begin miscompares++; $display("FAIL acc_clr_next: got %h expected %h", lut_addr, ph[31:22]); end
  endtask

  // Reference model: each frequency is a plateau lasting dwell+1 enabled cycles.
  task automatic run_sweep(input logic [31:0] st, input logic [31:0] sp, input logic [31:0] stp,
                           input logic [15:0] dw, input bit md, input bit preclear, input int n);
    longint      cur_q[$];
    int          st_q[$];
    bit          irq_q[$];
    longint      c, lst, lsp, lstp;
    int          s;
    bit          first;
    logic [31:0] d;
    logic [31:0] e;
    lst = st; lsp = sp; lstp = stp;
    c = lst;
    first = 1'b0;
    if (lst >= lsp) begin s = 3; first = 1'b1; end else s = 1;
    while (cur_q.size() < n) begin
      if (s == 3) begin
        cur_q.push_back(c); st_q.push_back(3); irq_q.push_back(first); first = 1'b0;
      end else begin
        for (int r = 0; r <= int'(dw); r++) begin
          cur_q.push_back(c); st_q.push_back(s); irq_q.push_back(1'b0);
        end
        if (s == 1) begin
          if (c + lstp >= lsp) begin
            c = lsp;
            if (md) s = 2; else begin s = 3; first = 1'b1; end
          end else c = c + lstp;
        end else begin
          if (c - lstp <= lst) begin c = lst; s = 1; end else c = c - lstp;
        end
      end
    end
    if (preclear) wr_reg(8'd5, 32'h1);
    wr_reg(8'd0, st);
    wr_reg(8'd1, sp);
    wr_reg(8'd2, stp);
    wr_reg(8'd3, {16'h0, dw});
    wr_reg(8'd5, {28'd0, 1'b1, md, 2'b11});
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      rd_reg(8'd7, d);
      e = 32'(cur_q[k]);
      vectors++; if (d !== e) begin miscompares++; $display("FAIL cur_fcw k=%0d: got %0d expected %0d", k, d, e); end
      rd_reg(8'd6, d);
      e = (st_q[k] == 3) ? 32'h7 : 32'(st_q[k]);
      vectors++; if (d !== e) begin miscompares++; $display("FAIL status k=%0d: got %h expected %h", k, d, e); end
      vectors++; if (sweep_irq !== irq_q[k]) begin miscompares++; $display("FAIL sweep_irq k=%0d: got %b expected %b", k, sweep_irq, irq_q[k]); end
    end
  endtask

  task automatic test_sweep_oneshot();
    run_sweep(32'd100, 32'd130, 32'd10, 16'd2, 1'b0, 1'b1, 16);
  endtask

  task automatic test_sweep_triangle();
    run_sweep(32'd100, 32'd130, 32'd10, 16'd2, 1'b1, 1'b1, 30);
    run_sweep(32'hffff_ff00, 32'hffff_fff0, 32'h40, 16'd0, 1'b1, 1'b1, 14);
    run_sweep(32'h0, 32'h50, 32'h30, 16'd1, 1'b1, 1'b1, 14);
  endtask

  task automatic test_degenerate();
    run_sweep(32'd200, 32'd100, 32'd10, 16'd2, 1'b0, 1'b1, 4);
    run_sweep(32'd5, 32'd50, 32'd0, 16'd1, 1'b0, 1'b1, 8);
  endtask

  task automatic test_restart();
    run_sweep(32'd40, 32'd70, 32'd15, 16'd1, 1'b0, 1'b1, 10);
    run_sweep(32'd40, 32'd70, 32'd15, 16'd1, 1'b0, 1'b0, 10);
  endtask

  task automatic test_sweep_disable();
    logic [31:0] d;
    run_sweep(32'd100, 32'd130, 32'd10, 16'd2, 1'b1, 1'b1, 8);
    wr_reg(8'd5, 32'h1);
    @(posedge clk); #1;
    rd_reg(8'd6, d);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL disable_status: got %h expected 0", d); end
    rd_reg(8'd7, d);
    vectors++; if (d !== 32'd100) begin miscompares++; $display("FAIL disable_cur: got %0d expected 100", d); end
    wr_reg(8'd0, 32'd555);
    @(posedge clk); #1;
    rd_reg(8'd7, d);
    vectors++; if (d !== 32'd555) begin miscompares++; $display("FAIL idle_track: got %0d expected 555", d); end
  endtask

  task automatic test_random_sweeps();
    logic [31:0] st;
    for (int i = 0; i < 6; i++) begin
      st = $urandom_range(0, 2000);
      run_sweep(st, st + $urandom_range(1, 200), $urandom_range(1, 60),
                16'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1, 40);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    run_sweep(32'd10, 32'd90, 32'd7, 16'd1, 1'b1, 1'b1, 6);
    #3;
    rst_ = 1'b0;
    #1;
    rd_reg(8'd6, d);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL arst_status: got %h expected 0", d); end
    rd_reg(8'd7, d);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL arst_cur: got %h expected 0", d); end
    rd_reg(8'd1, d);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL arst_stop: got %h expected 0", d); end
    vectors++; if (dout_vld !== 1'b0) begin miscompares++; $display("FAIL arst_vld: got %b expected 0", dout_vld); end
    vectors++; if (sin_dout !== 16'h0) begin miscompares++; $display("FAIL arst_sin: got %h expected 0", sin_dout); end
    @(posedge clk); #3;
    rst_ = 1'b1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_ = 1'b0;
    bus.icb_wr = 1'b0;
    bus.icb_wadr = 8'h0;
    bus.icb_wdat = 32'h0;
    bus.icb_rd = 1'b0;
    bus.icb_radr = 8'h0;
    test_reset();
    test_regs();
    test_acc();
    test_phase_ofs();
    test_acc_clr();
    test_sweep_oneshot();
    test_sweep_triangle();
    test_degenerate();
    test_restart();
    test_sweep_disable();
    test_random_sweeps();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
